multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Parametrised multicycle control FSM for the task_3 CPU datapath. It sequences fetch, decode, execute, memory and writeback phases per opcode class. Instruction length varies by class, not a fixed four cycles. It adds a memory ready handshake with wait states, conditional branch, HALT and illegal-opcode detection. It drives the same datapath strobes as the current control unit.

## Interface
- OPCODE_W, 4: opcode width, must be ≥4; bits above [3:0] are reserved and must be zero.
- MEM_TIMEOUT, 16: maximum wait cycles for mem_ready; used only with the watchdog compiled in.
- clock  in  1  system clock, rising edge.
- reset  in  1  one clock; reset is synchronous and active-low.
- flag  in  1  ALU zero flag, sampled in EXEC.
- opcode  in  OPCODE_W  from instruction register; registered internally in DECODE.
- mem_ready  in  1  memory completes current access this cycle.
- inst_wr  out  1  load instruction register.
- decoder_en  out  1  enable instruction decoder.
- pc_op  out  2  00 HOLD, 01 INC, 10 LOAD, 11 never driven.
- reg_en  out  1  register file read enable.
- rD_wr  out  1  destination register write.
- imm_en  out  1  select immediate operand.
- adrs_ctrl  out  1  memory address source: 0 PC, 1 ALU result.
- mem_rd / mem_wr  out  1 each  memory read / write request.
- halted  out  1  FSM is in HALT.
- illegal  out  1  one-cycle pulse on reserved opcode.
- bus_err  out  1  sticky memory-timeout error.

## Operation
- Opcode map uses the low 4 bits:
  - 0x0 NOP
  - 0x1–0x7 ALU reg-reg
  - 0x8 LDI
  - 0x9 LD
  - 0xA ST
  - 0xB JMP
  - 0xC BRZ
  - 0xD–0xE ALU-imm
  - 0xF HALT
- States: RST, FETCH, DECODE, EXEC, MEM, WB, HALT. All outputs are decoded from state plus the registered opcode class. Unlisted outputs are 0.
- RST: all outputs 0. Next state is FETCH unconditionally.
- FETCH:
  - Outputs: mem_rd=1, adrs_ctrl=0.
  - While mem_ready=0: stay; pc_op=HOLD.
  - When mem_ready=1: inst_wr=1, pc_op=INC, next state DECODE.
- DECODE: decoder_en=1, reg_en=1. Opcode is registered here.
  - Nonzero reserved bits: illegal=1, treat as NOP.
  - NOP goes to FETCH.
  - HALT goes to HALT.
  - All other classes go to EXEC.
- EXEC: reg_en=1. imm_en=1 for LDI, LD, ST and ALU-imm.
  - JMP: pc_op=LOAD, next FETCH.
  - BRZ: pc_op=LOAD if flag=1, else HOLD; next FETCH.
  - ALU, ALU-imm, LDI: next WB.
  - LD, ST: next MEM.
- MEM: adrs_ctrl=1, with mem_rd (LD) or mem_wr (ST) held until mem_ready=1.
  - LD then goes to WB.
  - ST then goes to FETCH.
- WB: rD_wr=1 for exactly one cycle, next FETCH.
- HALT: all strobes 0, halted=1. Left only by reset.
- Reset low in any state: RST on the next edge. A pending memory request is dropped after that edge.

## Timing
- Zero-wait latencies (mem_ready held high):
  - NOP: 2 cycles.
  - JMP, BRZ: 3 cycles.
  - ALU, ALU-imm, LDI, ST: 4 cycles.
  - LD: 5 cycles.
- Each wait cycle in FETCH or MEM adds one cycle. Request strobes stay stable throughout the wait.
- mem_ready is ignored outside FETCH and MEM.
- First FETCH occurs 1 cycle after reset deasserts.
- Reset values of every output are 0, including halted, illegal and bus_err.

## Configuration
- Macro: CTRL_MEM_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entering FETCH or MEM.
  - If MEM_TIMEOUT consecutive cycles pass with mem_ready=0, bus_err is set and the FSM goes to HALT.
  - bus_err is cleared only by reset.
- Undefined: the FSM waits indefinitely and bus_err is tied 0. The port exists in both builds.

## Structure
- Package ctrl_pkg holds:
  - state enum;
  - PC_HOLD / PC_INC / PC_LOAD constants;
  - opcode constants;
  - class enum (NOP, ALU, ALUI, LDI, LD, ST, JMP, BRZ, HALT).
- One sub-module, ctrl_opdecode: combinational opcode-to-class mapping plus reserved-bit check.

## Test plan
- ALU opcode 0x1 with mem_ready=1 → FETCH/DECODE/EXEC/WB over 4 cycles; inst_wr in cycle 1, rD_wr in cycle 4; pc_op=01 only in cycle 1.
- LD 0x9 with 2 wait states in MEM → mem_rd and adrs_ctrl=1 held 3 cycles, rD_wr next; total 7 cycles.
- BRZ 0xC with flag=1 → pc_op=10 in EXEC. Repeat with flag=0 → pc_op=00; both take 3 cycles.
- HALT 0xF → halted=1 and all strobes 0 for 20+ cycles. Reset low for 1 cycle → RST, then FETCH.
- Reset asserted mid-MEM during an ST wait → mem_wr=0 after the next edge, then RST → FETCH.
- OPCODE_W=6, opcode 0x11 → illegal pulses for 1 cycle in DECODE and returns to FETCH.
- With CTRL_MEM_TIMEOUT_EN, MEM_TIMEOUT=4 and mem_ready stuck 0 in FETCH → bus_err=1 and halted=1 after 4 wait cycles.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// ctrl_pkg: shared types and constants for the multicycle control FSM.
//   state_t     FSM states (exported on the debug port of multicycle_ctrl)
//   op_class_t  opcode classes produced by ctrl_opdecode
//   PC_*        pc_op encodings
//   OP_*        low-nibble opcode values
//   uses_imm()  classes that select the immediate operand in EXEC
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        CLS_NOP  = 4'd0,
        CLS_ALU  = 4'd1,
        CLS_ALUI = 4'd2,
        CLS_LDI  = 4'd3,
        CLS_LD   = 4'd4,
        CLS_ST   = 4'd5,
        CLS_JMP  = 4'd6,
        CLS_BRZ  = 4'd7,
        CLS_HALT = 4'd8
    } op_class_t;

    localparam logic [1:0] PC_HOLD = 2'b00;
    localparam logic [1:0] PC_INC  = 2'b01;
    localparam logic [1:0] PC_LOAD = 2'b10;

    // Low-nibble opcode map. 0x1-0x7 are ALU reg-reg, 0xD-0xE ALU-imm.
    localparam logic [3:0] OP_NOP       = 4'h0;
    localparam logic [3:0] OP_LDI       = 4'h8;
    localparam logic [3:0] OP_LD        = 4'h9;
    localparam logic [3:0] OP_ST        = 4'hA;
    localparam logic [3:0] OP_JMP       = 4'hB;
    localparam logic [3:0] OP_BRZ       = 4'hC;
    localparam logic [3:0] OP_ALUI_BASE = 4'hD;
    localparam logic [3:0] OP_HALT      = 4'hF;

    function automatic logic uses_imm(input op_class_t c);
        return (c == CLS_LDI) || (c == CLS_LD) || (c == CLS_ST) || (c == CLS_ALUI);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: control-unit <-> datapath/memory signal bundle.
//   master  : the control FSM (drives strobes, reads opcode/flag/mem_ready)
//   slave   : the datapath and memory side
// Memory handshake: mem_rd / mem_wr is the request and stays asserted and
// stable until the cycle in which mem_ready is high; that cycle completes
// the access. mem_ready has no meaning while no request is asserted.
interface multicycle_ctrl_if #(
    parameter int OPCODE_W = 4
);
    logic [OPCODE_W-1:0] opcode;
    logic                flag;
    logic                mem_ready;
    logic                inst_wr;
    logic                decoder_en;
    logic [1:0]          pc_op;
    logic                reg_en;
    logic                rD_wr;
    logic                imm_en;
    logic                adrs_ctrl;
    logic                mem_rd;
    logic                mem_wr;
    logic                halted;
    logic                illegal;
    logic                bus_err;

    modport master (
        input  opcode, flag, mem_ready,
        output inst_wr, decoder_en, pc_op, reg_en, rD_wr, imm_en,
               adrs_ctrl, mem_rd, mem_wr, halted, illegal, bus_err
    );

    modport slave (
        output opcode, flag, mem_ready,
        input  inst_wr, decoder_en, pc_op, reg_en, rD_wr, imm_en,
               adrs_ctrl, mem_rd, mem_wr, halted, illegal, bus_err
    );
endinterface

// File: rtl/multicycle_ctrl_opdecode.sv
// ctrl_opdecode: combinational opcode-to-class mapping.
//   opcode        in  OPCODE_W  raw opcode from the instruction register
//   op_class      out           decoded class (NOP when reserved bits set)
//   reserved_bad  out           any opcode bit above [3:0] is nonzero
module ctrl_opdecode
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4
) (
    input  logic [OPCODE_W-1:0] opcode,
    output op_class_t           op_class,
    output logic                reserved_bad
);
    logic [3:0] lo;

    assign lo = opcode[3:0];
    // For OPCODE_W == 4 the shift leaves nothing, so this is constant 0.
    assign reserved_bad = |(opcode >> 4);

    always_comb begin
        op_class = CLS_NOP;
        case (lo)
            OP_NOP:  op_class = CLS_NOP;
            OP_LDI:  op_class = CLS_LDI;
            OP_LD:   op_class = CLS_LD;
            OP_ST:   op_class = CLS_ST;
            OP_JMP:  op_class = CLS_JMP;
            OP_BRZ:  op_class = CLS_BRZ;
            OP_HALT: op_class = CLS_HALT;
            // Remaining codes are 0x1-0x7 (ALU) and 0xD-0xE (ALU-imm).
            default: op_class = (lo >= OP_ALUI_BASE) ? CLS_ALUI : CLS_ALU;
        endcase
        if (reserved_bad) begin
            op_class = CLS_NOP;
        end
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle control FSM for the CPU datapath.
// Sequences FETCH / DECODE / EXEC / MEM / WB per opcode class, with memory
// wait states, conditional branch, HALT and illegal-opcode detection.
//   clock      in   rising-edge clock
//   reset      in   synchronous, active-low
//   bus        master modport of multicycle_ctrl_if (opcode, flag,
//              mem_ready in; all datapath/memory strobes and status out)
//   dbg_state  out  current FSM state
// Build option: CTRL_MEM_TIMEOUT_EN adds a memory-wait watchdog. After
// MEM_TIMEOUT consecutive cycles without mem_ready in FETCH or MEM it sets
// the sticky bus_err and halts. Without it bus_err is tied 0.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 4,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                clock,
    input  logic                reset,
    multicycle_ctrl_if.master   bus,
    output state_t              dbg_state
);
    if (OPCODE_W < 4 || MEM_TIMEOUT < 1) begin : g_bad_params
        $error("multicycle_ctrl: OPCODE_W must be >= 4 and MEM_TIMEOUT >= 1");
    end

    state_t    state;
    op_class_t op_class;      // class captured in DECODE
    op_class_t dec_class;     // live decode of bus.opcode
    logic      dec_bad;
    logic      timeout_hit;

    ctrl_opdecode #(.OPCODE_W(OPCODE_W)) u_opdecode (
        .opcode       (bus.opcode),
        .op_class     (dec_class),
        .reserved_bad (dec_bad)
    );

`ifdef CTRL_MEM_TIMEOUT_EN
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    logic [WAIT_W-1:0] wait_cnt;
    logic              bus_err_q;
    logic              in_wait_state;

    assign in_wait_state = (state == ST_FETCH) || (state == ST_MEM);
    // Fires on the MEM_TIMEOUT-th consecutive cycle without mem_ready.
    assign timeout_hit = in_wait_state && !bus.mem_ready &&
                         (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

    // Counter is zero whenever FETCH or MEM is entered: it is held at 0 in
    // every other state and cleared when an access completes.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wait_cnt  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            if (in_wait_state && !bus.mem_ready && !timeout_hit) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (timeout_hit) begin
                bus_err_q <= 1'b1;
            end
        end
    end

    assign bus.bus_err = bus_err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus.bus_err = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= ST_RST;
            op_class <= CLS_NOP;
        end else begin
            case (state)
                ST_RST: state <= ST_FETCH;
                ST_FETCH: begin
                    if (bus.mem_ready) begin
                        state <= ST_DECODE;
                    end else if (timeout_hit) begin
                        state <= ST_HALT;
                    end
                end
                ST_DECODE: begin
                    op_class <= dec_class;
                    case (dec_class)
                        CLS_NOP:  state <= ST_FETCH;
                        CLS_HALT: state <= ST_HALT;
                        default:  state <= ST_EXEC;
                    endcase
                end
                ST_EXEC: begin
                    case (op_class)
                        CLS_JMP, CLS_BRZ: state <= ST_FETCH;
                        CLS_LD, CLS_ST:   state <= ST_MEM;
                        default:          state <= ST_WB;
                    endcase
                end
                ST_MEM: begin
                    if (bus.mem_ready) begin
                        state <= (op_class == CLS_LD) ? ST_WB : ST_FETCH;
                    end else if (timeout_hit) begin
                        state <= ST_HALT;
                    end
                end
                ST_WB:   state <= ST_FETCH;
                ST_HALT: state <= ST_HALT;
                default: state <= ST_RST;
            endcase
        end
    end

    // Strobes decode from state and captured class; FETCH completion and
    // the BRZ target select follow the live mem_ready / flag inputs.
    always_comb begin
        bus.inst_wr    = 1'b0;
        bus.decoder_en = 1'b0;
        bus.pc_op      = PC_HOLD;
        bus.reg_en     = 1'b0;
        bus.rD_wr      = 1'b0;
        bus.imm_en     = 1'b0;
        bus.adrs_ctrl  = 1'b0;
        bus.mem_rd     = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.halted     = 1'b0;
        bus.illegal    = 1'b0;
        case (state)
            ST_FETCH: begin
                bus.mem_rd = 1'b1;
                if (bus.mem_ready) begin
                    bus.inst_wr = 1'b1;
                    bus.pc_op   = PC_INC;
                end
            end
            ST_DECODE: begin
                bus.decoder_en = 1'b1;
                bus.reg_en     = 1'b1;
                bus.illegal    = dec_bad;
            end
            ST_EXEC: begin
                bus.reg_en = 1'b1;
                bus.imm_en = uses_imm(op_class);
                if (op_class == CLS_JMP || (op_class == CLS_BRZ && bus.flag)) begin
                    bus.pc_op = PC_LOAD;
                end
            end
            ST_MEM: begin
                bus.adrs_ctrl = 1'b1;
                bus.mem_rd    = (op_class == CLS_LD);
                bus.mem_wr    = (op_class == CLS_ST);
            end
            ST_WB:   bus.rD_wr  = 1'b1;
            ST_HALT: bus.halted = 1'b1;
            default: ;
        endcase
    end

    assign dbg_state = state;
endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
    import ctrl_pkg::*;

    // Strobe bit masks: {inst_wr, decoder_en, pc_op[1:0], reg_en, rD_wr,
    // imm_en, adrs_ctrl, mem_rd, mem_wr, halted, illegal, bus_err}
    localparam logic [12:0] IW  = 13'h1000;
    localparam logic [12:0] DE  = 13'h0800;
    localparam logic [12:0] PCL = 13'h0400;
    localparam logic [12:0] PCI = 13'h0200;
    localparam logic [12:0] RE  = 13'h0100;
    localparam logic [12:0] RW  = 13'h0080;
    localparam logic [12:0] IE  = 13'h0040;
    localparam logic [12:0] AC  = 13'h0020;
    localparam logic [12:0] MR  = 13'h0010;
    localparam logic [12:0] MW  = 13'h0008;
    localparam logic [12:0] HL  = 13'h0004;
    localparam logic [12:0] IL  = 13'h0002;
    localparam logic [12:0] BE  = 13'h0001;

    logic   clock;
    logic   reset;
    state_t dbg_state;
    int     checks;
    int     failures;

    logic [15:0] exp_q[$];
    string       tag_q[$];

    multicycle_ctrl_if #(.OPCODE_W(6)) bus ();

    multicycle_ctrl #(.OPCODE_W(6), .MEM_TIMEOUT(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL time_limit got=running exp=finished");
        $fatal(1, "time limit");
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (state|strobes) t=%0t", tag, got, exp, $time);
        end
    endtask

    // scoreboard: one expected vector per driven cycle, compared mid-cycle
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            logic [15:0] e;
            string       t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check_eq(t, {3'(dbg_state), bus.inst_wr, bus.decoder_en, bus.pc_op,
                         bus.reg_en, bus.rD_wr, bus.imm_en, bus.adrs_ctrl,
                         bus.mem_rd, bus.mem_wr, bus.halted, bus.illegal,
                         bus.bus_err}, e);
        end
    end

    function automatic logic [15:0] mk(input state_t st, input logic [12:0] s);
        return {3'(st), s};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [5:0] junk();
        return 6'($urandom_range(0, 63));
    endfunction

    function automatic op_class_t cls_of(input logic [3:0] lo);
        case (lo)
            4'h0:                         return CLS_NOP;
            4'h1, 4'h2, 4'h3, 4'h4,
            4'h5, 4'h6, 4'h7:             return CLS_ALU;
            4'h8:                         return CLS_LDI;
            4'h9:                         return CLS_LD;
            4'hA:                         return CLS_ST;
            4'hB:                         return CLS_JMP;
            4'hC:                         return CLS_BRZ;
            4'hD, 4'hE:                   return CLS_ALUI;
            default:                      return CLS_HALT;
        endcase
    endfunction

    // driver: one clock cycle of inputs plus its expected outputs
    task automatic step(input logic [15:0] exp, input logic mr, input logic [5:0] op,
                        input logic flg, input logic rst_n, input string tag);
        reset         = rst_n;
        bus.mem_ready = mr;
        bus.opcode    = op;
        bus.flag      = flg;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge clock);
        #1;
    endtask

    // One instruction starting in FETCH; HALT/NOP/illegal stop after DECODE.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                             input logic flg, input string name);
        op_class_t   c;
        logic        bad;
        logic [12:0] s;
        bad = (op[5:4] != 2'b00);
        c   = bad ? CLS_NOP : cls_of(op[3:0]);
        for (int i = 0; i < fw; i++)
            step(mk(ST_FETCH, MR), 1'b0, op, rb(), 1'b1, {name, "_fwait"});
        step(mk(ST_FETCH, MR | IW | PCI), 1'b1, op, rb(), 1'b1, {name, "_fetch"});
        step(mk(ST_DECODE, DE | RE | (bad ? IL : 13'h0)), rb(), op, rb(), 1'b1, {name, "_decode"});
        if (c == CLS_NOP || c == CLS_HALT) return;
        s = RE;
        if (c == CLS_LDI || c == CLS_LD || c == CLS_ST || c == CLS_ALUI) s = s | IE;
        if (c == CLS_JMP || (c == CLS_BRZ && flg)) s = s | PCL;
        // opcode scrambled after DECODE: the captured class must be used
        step(mk(ST_EXEC, s), rb(), junk(), flg, 1'b1, {name, "_exec"});
        if (c == CLS_LD || c == CLS_ST) begin
            s = AC | ((c == CLS_LD) ? MR : MW);
            for (int i = 0; i < mw; i++)
                step(mk(ST_MEM, s), 1'b0, junk(), rb(), 1'b1, {name, "_mwait"});
            step(mk(ST_MEM, s), 1'b1, junk(), rb(), 1'b1, {name, "_mem"});
        end
        if (c == CLS_ALU || c == CLS_ALUI || c == CLS_LDI || c == CLS_LD)
            step(mk(ST_WB, RW), rb(), junk(), rb(), 1'b1, {name, "_wb"});
    endtask

    initial begin
        logic [3:0] lo;
        checks        = 0;
        failures      = 0;
        reset         = 1'b0;
        bus.mem_ready = 1'b0;
        bus.opcode    = '0;
        bus.flag      = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        step(mk(ST_RST, 13'h0), 1'b1, 6'h0, 1'b0, 1'b0, "reset_state");
        step(mk(ST_RST, 13'h0), 1'b1, 6'h0, 1'b0, 1'b1, "reset_release");

        run_instr(6'h01, 0, 0, 1'b0, "alu");
        run_instr(6'h09, 0, 2, 1'b0, "ld_wait2");
        run_instr(6'h0C, 0, 0, 1'b1, "brz_taken");
        run_instr(6'h0C, 0, 0, 1'b0, "brz_not");
        run_instr(6'h0B, 1, 0, 1'b0, "jmp");
        run_instr(6'h00, 0, 0, 1'b0, "nop");
        run_instr(6'h08, 0, 0, 1'b0, "ldi");
        run_instr(6'h0A, 2, 1, 1'b0, "st");
        run_instr(6'h0D, 0, 0, 1'b1, "alui_d");
        run_instr(6'h0E, 0, 0, 1'b0, "alui_e");
        run_instr(6'h11, 0, 0, 1'b0, "illegal");
        run_instr(6'h09, 0, 0, 1'b1, "ld");

        for (int n = 0; n < 12; n++) begin
            lo = 4'($urandom_range(0, 14));
            run_instr({2'b00, lo}, $urandom_range(0, 2), $urandom_range(0, 2), rb(), "rand");
        end

        // reset while an ST is waiting in MEM
        step(mk(ST_FETCH, MR | IW | PCI), 1'b1, 6'h0A, 1'b0, 1'b1, "strst_fetch");
        step(mk(ST_DECODE, DE | RE), 1'b1, 6'h0A, 1'b0, 1'b1, "strst_decode");
        step(mk(ST_EXEC, RE | IE), 1'b1, junk(), 1'b0, 1'b1, "strst_exec");
        step(mk(ST_MEM, AC | MW), 1'b0, junk(), 1'b0, 1'b1, "strst_mwait");
        step(mk(ST_MEM, AC | MW), 1'b0, junk(), 1'b0, 1'b0, "strst_edge");
        step(mk(ST_RST, 13'h0), 1'b1, junk(), 1'b0, 1'b1, "strst_dropped");
        run_instr(6'h03, 0, 0, 1'b0, "after_strst");

        // HALT holds until reset
        run_instr(6'h0F, 0, 0, 1'b0, "halt");
        for (int i = 0; i < 22; i++)
            step(mk(ST_HALT, HL), rb(), junk(), rb(), 1'b1, "halt_hold");
        step(mk(ST_HALT, HL), rb(), junk(), rb(), 1'b0, "halt_rst");
        step(mk(ST_RST, 13'h0), rb(), junk(), rb(), 1'b1, "halt_to_rst");
        run_instr(6'h02, 0, 0, 1'b0, "after_halt");

`ifdef CTRL_MEM_TIMEOUT_EN
        for (int i = 0; i < 4; i++)
            step(mk(ST_FETCH, MR), 1'b0, 6'h01, 1'b0, 1'b1, "tmo_wait");
        for (int i = 0; i < 5; i++)
            step(mk(ST_HALT, HL | BE), rb(), junk(), rb(), 1'b1, "tmo_halt");
        step(mk(ST_HALT, HL | BE), rb(), junk(), rb(), 1'b0, "tmo_rst");
        step(mk(ST_RST, 13'h0), rb(), junk(), rb(), 1'b1, "tmo_cleared");
        run_instr(6'h01, 3, 0, 1'b0, "after_tmo");
`endif

        @(negedge clock);
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
